// File: rtl/axi_lite_ptgen_master.sv
// AXI4-Lite pattern-generator master. Each pass writes NUM_TXN words of an
// incrementing or LFSR pattern from BASE_ADDR upward, then reads them back
// and compares. It reports done, a sticky error, a saturating error count
// and a sticky per-handshake timeout. Only one transaction is in flight.
// DATA_W must be 32 or 64.
module axi_lite_ptgen_master #(
  parameter int unsigned          ADDR_W       = 32,
  parameter int unsigned          DATA_W       = 32,
  parameter int unsigned          NUM_TXN      = 4,
  parameter logic [ADDR_W-1:0]    BASE_ADDR    = 32'h4000_0000,
  parameter int unsigned          PATTERN_MODE = 0,
  parameter logic [31:0]          SEED         = 32'h0000_0001,
  parameter int unsigned          TIMEOUT_CYC  = 1024
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                INIT_AXI_TXN,
  output logic                TXN_DONE,
  output logic                ERROR,
  output logic [15:0]         ERR_COUNT,
  output logic                TIMEOUT,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [2:0]          M_AXI_AWPROT,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic [2:0]          M_AXI_ARPROT,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
);

  localparam int unsigned IW       = (NUM_TXN > 1) ? $clog2(NUM_TXN) : 1;
  localparam int unsigned TW       = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BSHIFT   = (DATA_W == 64) ? 3 : 2;
  localparam int unsigned LANES    = DATA_W / 32;
  localparam bit          TMO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_TXN - 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYC);
  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [31:0]     pat_q, pat_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            aw_ok_q, aw_ok_d;
  logic            w_ok_q, w_ok_d;
  logic            arvalid_q, arvalid_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            tmo_flag_q, tmo_flag_d;
  logic [15:0]     errcnt_q, errcnt_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            init_q;

  logic            init_pulse;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] pat_word;
  logic [31:0]     pat_next;
  logic [15:0]     errcnt_inc;
  logic            aw_acc, w_acc, b_acc, ar_acc, r_acc, hs;
  logic            waiting, tmo_hit, last;

  assign init_pulse = INIT_AXI_TXN & ~init_q;
  assign addr       = BASE_ADDR + (ADDR_W'(idx_q) << BSHIFT);
  assign errcnt_inc = (errcnt_q == 16'hFFFF) ? errcnt_q : errcnt_q + 16'd1;
  assign last       = (idx_q == LAST_IDX);

  assign aw_acc  = awvalid_q & M_AXI_AWREADY;
  assign w_acc   = wvalid_q & M_AXI_WREADY;
  assign b_acc   = (state_q == S_WR_RESP) & M_AXI_BVALID;
  assign ar_acc  = arvalid_q & M_AXI_ARREADY;
  assign r_acc   = (state_q == S_RD_DATA) & M_AXI_RVALID;
  assign hs      = aw_acc | w_acc | b_acc | ar_acc | r_acc;
  assign waiting = (state_q == S_WR_ADDR) || (state_q == S_WR_RESP) ||
                   (state_q == S_RD_ADDR) || (state_q == S_RD_DATA);
  // A handshake in the same cycle counts as progress, so it wins over the limit
  assign tmo_hit = TMO_EN && waiting && !hs && (tmo_cnt_q == TMO_LIMIT);

  // Pattern word per 32-bit lane: LFSR replicates, incrementing zero-extends
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    if (PATTERN_MODE == 1 || gi == 0) begin : g_copy
      assign pat_word[gi*32 +: 32] = pat_q;
    end else begin : g_zero
      assign pat_word[gi*32 +: 32] = 32'h0;
    end
  end

  if (PATTERN_MODE == 1) begin : g_lfsr
    assign pat_next = {1'b0, pat_q[31:1]} ^ (pat_q[0] ? LFSR_MASK : 32'h0);
  end else begin : g_inc
    assign pat_next = pat_q + 32'd1;
  end

  assign TXN_DONE      = done_q;
  assign ERROR         = err_q;
  assign ERR_COUNT     = errcnt_q;
  assign TIMEOUT       = tmo_flag_q;
  assign M_AXI_AWADDR  = addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = pat_word;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (state_q == S_WR_RESP);
  assign M_AXI_ARADDR  = addr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = (state_q == S_RD_DATA);

  // Next-state, channel valids, index/pattern stepping and status flags
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pat_d      = pat_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    aw_ok_d    = aw_ok_q;
    w_ok_d     = w_ok_q;
    arvalid_d  = arvalid_q;
    done_d     = done_q;
    err_d      = err_q;
    tmo_flag_d = tmo_flag_q;
    errcnt_d   = errcnt_q;
    if ((state_q == S_IDLE || state_q == S_DONE) && init_pulse) begin
      state_d    = S_WR_ADDR;
      idx_d      = '0;
      pat_d      = SEED;
      done_d     = 1'b0;
      err_d      = 1'b0;
      tmo_flag_d = 1'b0;
      errcnt_d   = 16'd0;
    end else if (tmo_hit) begin
      state_d    = S_DONE;
      awvalid_d  = 1'b0;
      wvalid_d   = 1'b0;
      arvalid_d  = 1'b0;
      aw_ok_d    = 1'b0;
      w_ok_d     = 1'b0;
      done_d     = 1'b1;
      err_d      = 1'b1;
      tmo_flag_d = 1'b1;
    end else begin
      case (state_q)
        S_WR_ADDR: begin
          // Both valids rise together on the cycle after entry
          if (!awvalid_q && !aw_ok_q) awvalid_d = 1'b1;
          if (!wvalid_q && !w_ok_q)   wvalid_d  = 1'b1;
          if (aw_acc) begin
            awvalid_d = 1'b0;
            aw_ok_d   = 1'b1;
          end
          if (w_acc) begin
            wvalid_d = 1'b0;
            w_ok_d   = 1'b1;
          end
          if ((aw_ok_q || aw_acc) && (w_ok_q || w_acc)) begin
            state_d = S_WR_RESP;
            aw_ok_d = 1'b0;
            w_ok_d  = 1'b0;
          end
        end
        S_WR_RESP: begin
          if (b_acc) begin
            if (M_AXI_BRESP != 2'b00) begin
              err_d    = 1'b1;
              errcnt_d = errcnt_inc;
            end
            if (last) begin
              idx_d   = '0;
              pat_d   = SEED;
              state_d = S_RD_ADDR;
            end else begin
              idx_d   = idx_q + 1'b1;
              pat_d   = pat_next;
              state_d = S_WR_ADDR;
            end
          end
        end
        S_RD_ADDR: begin
          if (!arvalid_q) arvalid_d = 1'b1;
          if (ar_acc) begin
            arvalid_d = 1'b0;
            state_d   = S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (r_acc) begin
            if (M_AXI_RDATA != pat_word || M_AXI_RRESP != 2'b00) begin
              err_d    = 1'b1;
              errcnt_d = errcnt_inc;
            end
            if (last) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + 1'b1;
              pat_d   = pat_next;
              state_d = S_RD_ADDR;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Per-handshake watchdog: restarts on state entry or any accepted handshake
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_d != state_q || hs) begin
      tmo_cnt_d = '0;
    end else if (TMO_EN && waiting) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  // State and status registers with synchronous reset
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      pat_q      <= SEED;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      aw_ok_q    <= 1'b0;
      w_ok_q     <= 1'b0;
      arvalid_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tmo_flag_q <= 1'b0;
      errcnt_q   <= 16'd0;
      tmo_cnt_q  <= '0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pat_q      <= pat_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      aw_ok_q    <= aw_ok_d;
      w_ok_q     <= w_ok_d;
      arvalid_q  <= arvalid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tmo_flag_q <= tmo_flag_d;
      errcnt_q   <= errcnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      init_q     <= INIT_AXI_TXN;
    end
  end

endmodule

// File: tb/tb_axi_lite_ptgen_master.sv
// Bench for axi_lite_ptgen_master: instance A (incrementing, 4 words,
// 64-cycle timeout) behind a zero-wait memory slave with fault knobs, and
// instance B (LFSR, 16 words) behind a memory slave with random 0..7 delays.
module tb_axi_lite_ptgen_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- instance A ----------------
  logic rst_a, init_a, done_a, err_a, to_a;
  logic [15:0] errcnt_a;
  logic [31:0] awaddr_a, wdata_a, araddr_a, rdata_a;
  logic [2:0]  awprot_a, arprot_a;
  logic [3:0]  wstrb_a;
  logic awvalid_a, awready_a, wvalid_a, wready_a, bvalid_a, bready_a;
  logic arvalid_a, arready_a, rvalid_a, rready_a;
  logic [1:0] bresp_a, rresp_a;
  logic ar_block = 1'b0, b_hold = 1'b0, r_hold = 1'b0;
  int corrupt_idx = -1, slverr_idx = -1;

  assign awready_a = 1'b1;
  assign wready_a  = 1'b1;
  assign arready_a = ~ar_block;

  axi_lite_ptgen_master #(.NUM_TXN(4), .PATTERN_MODE(0), .TIMEOUT_CYC(64)) dut_a (
    .ACLK(clk), .ARESET(rst_a), .INIT_AXI_TXN(init_a),
    .TXN_DONE(done_a), .ERROR(err_a), .ERR_COUNT(errcnt_a), .TIMEOUT(to_a),
    .M_AXI_AWADDR(awaddr_a), .M_AXI_AWPROT(awprot_a), .M_AXI_AWVALID(awvalid_a), .M_AXI_AWREADY(awready_a),
    .M_AXI_WDATA(wdata_a), .M_AXI_WSTRB(wstrb_a), .M_AXI_WVALID(wvalid_a), .M_AXI_WREADY(wready_a),
    .M_AXI_BRESP(bresp_a), .M_AXI_BVALID(bvalid_a), .M_AXI_BREADY(bready_a),
    .M_AXI_ARADDR(araddr_a), .M_AXI_ARPROT(arprot_a), .M_AXI_ARVALID(arvalid_a), .M_AXI_ARREADY(arready_a),
    .M_AXI_RDATA(rdata_a), .M_AXI_RRESP(rresp_a), .M_AXI_RVALID(rvalid_a), .M_AXI_RREADY(rready_a)
  );

  logic [31:0] mem_a [16];
  logic [31:0] wlog_addr_a [64];
  logic [31:0] wlog_data_a [64];
  int wcnt_a = 0, rcnt_a = 0;
  logic awg_a, wg_a, rpend_a;
  logic [31:0] awq_a, wq_a, arq_a;

  // Slave A: zero-wait memory with knobs for SLVERR, read corruption and stalls
  always @(posedge clk) begin
    if (rst_a) begin
      bvalid_a <= 1'b0; rvalid_a <= 1'b0; bresp_a <= 2'b00; rresp_a <= 2'b00;
      rdata_a <= 32'h0; awg_a <= 1'b0; wg_a <= 1'b0; rpend_a <= 1'b0;
    end else begin
      if (awvalid_a && awready_a) begin awg_a <= 1'b1; awq_a <= awaddr_a; end
      if (wvalid_a && wready_a) begin wg_a <= 1'b1; wq_a <= wdata_a; end
      if (bvalid_a && bready_a) bvalid_a <= 1'b0;
      if (awg_a && wg_a && !bvalid_a && !b_hold) begin
        mem_a[awq_a[5:2]] <= wq_a;
        bresp_a <= (int'(awq_a[5:2]) == slverr_idx) ? 2'b10 : 2'b00;
        bvalid_a <= 1'b1; awg_a <= 1'b0; wg_a <= 1'b0;
        wlog_addr_a[wcnt_a % 64] <= awq_a;
        wlog_data_a[wcnt_a % 64] <= wq_a;
        wcnt_a <= wcnt_a + 1;
      end
      if (rvalid_a && rready_a) rvalid_a <= 1'b0;
      if (arvalid_a && arready_a) begin rpend_a <= 1'b1; arq_a <= araddr_a; end
      if (rpend_a && !rvalid_a && !r_hold) begin
        rdata_a <= mem_a[arq_a[5:2]] ^ ((int'(arq_a[5:2]) == corrupt_idx) ? 32'h1 : 32'h0);
        rresp_a <= 2'b00; rvalid_a <= 1'b1; rpend_a <= 1'b0;
        rcnt_a <= rcnt_a + 1;
      end
    end
  end

  // ---------------- instance B ----------------
  logic rst_b, init_b, done_b, err_b, to_b;
  logic [15:0] errcnt_b;
  logic [31:0] awaddr_b, wdata_b, araddr_b, rdata_b;
  logic [2:0]  awprot_b, arprot_b;
  logic [3:0]  wstrb_b;
  logic awvalid_b, awready_b, wvalid_b, wready_b, bvalid_b, bready_b;
  logic arvalid_b, arready_b, rvalid_b, rready_b;
  logic [1:0] bresp_b, rresp_b;
  int unsigned awd_b, wd_b, ard_b, rd_b;

  assign awready_b = awvalid_b && (awd_b == 0);
  assign wready_b  = wvalid_b && (wd_b == 0);
  assign arready_b = arvalid_b && (ard_b == 0);

  axi_lite_ptgen_master #(.NUM_TXN(16), .PATTERN_MODE(1)) dut_b (
    .ACLK(clk), .ARESET(rst_b), .INIT_AXI_TXN(init_b),
    .TXN_DONE(done_b), .ERROR(err_b), .ERR_COUNT(errcnt_b), .TIMEOUT(to_b),
    .M_AXI_AWADDR(awaddr_b), .M_AXI_AWPROT(awprot_b), .M_AXI_AWVALID(awvalid_b), .M_AXI_AWREADY(awready_b),
    .M_AXI_WDATA(wdata_b), .M_AXI_WSTRB(wstrb_b), .M_AXI_WVALID(wvalid_b), .M_AXI_WREADY(wready_b),
    .M_AXI_BRESP(bresp_b), .M_AXI_BVALID(bvalid_b), .M_AXI_BREADY(bready_b),
    .M_AXI_ARADDR(araddr_b), .M_AXI_ARPROT(arprot_b), .M_AXI_ARVALID(arvalid_b), .M_AXI_ARREADY(arready_b),
    .M_AXI_RDATA(rdata_b), .M_AXI_RRESP(rresp_b), .M_AXI_RVALID(rvalid_b), .M_AXI_RREADY(rready_b)
  );

  logic [31:0] mem_b [16];
  logic [31:0] wlog_addr_b [16];
  logic [31:0] wlog_data_b [16];
  int wcnt_b = 0, rcnt_b = 0;
  logic awg_b, wg_b, rpend_b;
  logic [31:0] awq_b, wq_b, arq_b;

  // Slave B: memory with random 0..7 cycle READY / RVALID delays
  always @(posedge clk) begin
    if (rst_b) begin
      bvalid_b <= 1'b0; rvalid_b <= 1'b0; bresp_b <= 2'b00; rresp_b <= 2'b00;
      rdata_b <= 32'h0; awg_b <= 1'b0; wg_b <= 1'b0; rpend_b <= 1'b0;
      awd_b <= $urandom_range(0, 7); wd_b <= $urandom_range(0, 7);
      ard_b <= $urandom_range(0, 7); rd_b <= 0;
    end else begin
      if (awvalid_b) awd_b <= (awd_b == 0) ? $urandom_range(0, 7) : awd_b - 1;
      if (wvalid_b)  wd_b  <= (wd_b == 0)  ? $urandom_range(0, 7) : wd_b - 1;
      if (arvalid_b) ard_b <= (ard_b == 0) ? $urandom_range(0, 7) : ard_b - 1;
      if (awvalid_b && awready_b) begin awg_b <= 1'b1; awq_b <= awaddr_b; end
      if (wvalid_b && wready_b) begin wg_b <= 1'b1; wq_b <= wdata_b; end
      if (bvalid_b && bready_b) bvalid_b <= 1'b0;
      if (awg_b && wg_b && !bvalid_b) begin
        mem_b[awq_b[5:2]] <= wq_b;
        bresp_b <= 2'b00; bvalid_b <= 1'b1; awg_b <= 1'b0; wg_b <= 1'b0;
        wlog_addr_b[wcnt_b % 16] <= awq_b;
        wlog_data_b[wcnt_b % 16] <= wq_b;
        wcnt_b <= wcnt_b + 1;
      end
      if (rvalid_b && rready_b) rvalid_b <= 1'b0;
      if (arvalid_b && arready_b) begin
        rpend_b <= 1'b1; arq_b <= araddr_b; rd_b <= $urandom_range(0, 7);
      end
      if (rpend_b && !rvalid_b) begin
        if (rd_b == 0) begin
          rdata_b <= mem_b[arq_b[5:2]]; rresp_b <= 2'b00; rvalid_b <= 1'b1;
          rpend_b <= 1'b0; rcnt_b <= rcnt_b + 1;
        end else begin
          rd_b <= rd_b - 1;
        end
      end
    end
  end

  // ---------------- protocol monitors ----------------
  logic [2:0]  pend_a, pend_b;
  logic [95:0] pay_a, pay_b;
  int viol_a = 0, viol_b = 0;

  // A pending VALID must stay high with a stable payload until READY
  always @(posedge clk) begin
    if (rst_a) begin
      pend_a <= 3'b000;
    end else begin
      if (!to_a && ((pend_a[0] && (!awvalid_a || awaddr_a != pay_a[31:0])) ||
                    (pend_a[1] && (!wvalid_a  || wdata_a  != pay_a[63:32])) ||
                    (pend_a[2] && (!arvalid_a || araddr_a != pay_a[95:64]))))
        viol_a <= viol_a + 1;
      pend_a <= {arvalid_a & ~arready_a, wvalid_a & ~wready_a, awvalid_a & ~awready_a};
      pay_a  <= {araddr_a, wdata_a, awaddr_a};
    end
  end

  always @(posedge clk) begin
    if (rst_b) begin
      pend_b <= 3'b000;
    end else begin
      if (!to_b && ((pend_b[0] && (!awvalid_b || awaddr_b != pay_b[31:0])) ||
                    (pend_b[1] && (!wvalid_b  || wdata_b  != pay_b[63:32])) ||
                    (pend_b[2] && (!arvalid_b || araddr_b != pay_b[95:64]))))
        viol_b <= viol_b + 1;
      pend_b <= {arvalid_b & ~arready_b, wvalid_b & ~wready_b, awvalid_b & ~awready_b};
      pay_b  <= {araddr_b, wdata_b, awaddr_b};
    end
  end

  // ---------------- helpers ----------------
  function automatic logic sig_a(input int sel);
    case (sel)
      0: return done_a;
      1: return rready_a;
      2: return bready_a;
      default: return arvalid_a;
    endcase
  endfunction

  task automatic wait_a(input int sel, input int max, output int cyc);
    cyc = 0;
    while (!sig_a(sel) && cyc < max) begin
      tick(1);
      cyc++;
    end
  endtask

  task automatic pulse_a();
    init_a = 1'b1;
    tick(1);
    init_a = 1'b0;
  endtask

  task automatic check_pass_a(input string tag, input int w0);
    logic [31:0] exp_addr [4];
    logic [31:0] exp_data [4];
    exp_addr = '{32'h4000_0000, 32'h4000_0004, 32'h4000_0008, 32'h4000_000C};
    exp_data = '{32'd1, 32'd2, 32'd3, 32'd4};
    for (int i = 0; i < 4; i++) begin
      check_val({tag, "_awaddr"}, wlog_addr_a[(w0 + i) % 64], exp_addr[i]);
      check_val({tag, "_wdata"}, wlog_data_a[(w0 + i) % 64], exp_data[i]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, w0, r0;
    logic [31:0] lfsr_exp [4];
    lfsr_exp = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001};
    rst_a = 1'b1; rst_b = 1'b1; init_a = 1'b0; init_b = 1'b0;
    tick(3);
    rst_a = 1'b0; rst_b = 1'b0;
    tick(1);

    // Reset state
    check_val("rst_outs_a", {awvalid_a, wvalid_a, bready_a, arvalid_a, rready_a,
                             done_a, err_a, to_a, errcnt_a}, 64'h0);
    check_val("const_prot_strb", {awprot_a, arprot_a, wstrb_a}, 64'h00F);

    // LFSR, 16 words, random slave delays
    init_b = 1'b1; tick(1); init_b = 1'b0;
    cyc = 0;
    while (!done_b && cyc < 3000) begin tick(1); cyc++; end
    check_val("b_done", done_b, 1);
    check_val("b_error", err_b, 0);
    check_val("b_errcnt", errcnt_b, 0);
    check_val("b_timeout", to_b, 0);
    check_val("b_writes", wcnt_b, 16);
    check_val("b_reads", rcnt_b, 16);
    for (int i = 0; i < 4; i++) check_val("b_lfsr_wdata", wlog_data_b[i], lfsr_exp[i]);
    check_val("b_last_awaddr", wlog_addr_b[15], 32'h4000_003C);
    check_val("b_valid_drops", viol_b, 0);

    // Basic incrementing pass
    w0 = wcnt_a; r0 = rcnt_a;
    pulse_a();
    wait_a(0, 200, cyc);
    check_val("p1_done", done_a, 1);
    check_pass_a("p1", w0);
    check_val("p1_reads", rcnt_a - r0, 4);
    check_val("p1_error", err_a, 0);
    check_val("p1_errcnt", errcnt_a, 0);

    // Corrupt read of word 2, SLVERR on write of word 3, INIT pulse in RD_DATA
    corrupt_idx = 2; slverr_idx = 3; r_hold = 1'b1;
    pulse_a();
    wait_a(1, 100, cyc);
    check_val("rd_data_reached", rready_a, 1);
    check_val("pre_ign_errcnt", errcnt_a, 1);
    init_a = 1'b1; tick(1); init_a = 1'b0;
    tick(2);
    check_val("ign_still_rd", rready_a, 1);
    check_val("ign_errcnt", errcnt_a, 1);
    check_val("ign_error", err_a, 1);
    r_hold = 1'b0;
    wait_a(0, 200, cyc);
    check_val("err_done", done_a, 1);
    check_val("err_error", err_a, 1);
    check_val("err_errcnt", errcnt_a, 2);
    check_val("err_timeout", to_a, 0);

    // Second INIT after DONE clears flags and repeats the pass
    corrupt_idx = -1; slverr_idx = -1;
    w0 = wcnt_a;
    pulse_a();
    check_val("p2_clr_done", done_a, 0);
    check_val("p2_clr_error", err_a, 0);
    check_val("p2_clr_errcnt", errcnt_a, 0);
    wait_a(0, 200, cyc);
    check_val("p2_done", done_a, 1);
    check_pass_a("p2", w0);
    check_val("p2_error", err_a, 0);

    // Held-high INIT runs exactly one pass
    w0 = wcnt_a;
    init_a = 1'b1;
    tick(1);
    wait_a(0, 200, cyc);
    tick(30);
    check_val("held_done", done_a, 1);
    check_val("held_writes", wcnt_a - w0, 4);
    init_a = 1'b0;
    tick(2);

    // ARREADY never asserted: timeout
    ar_block = 1'b1;
    pulse_a();
    wait_a(3, 200, cyc);
    check_val("to_arvalid_seen", arvalid_a, 1);
    wait_a(0, 200, cyc);
    check_val("to_latency_ok", (cyc >= 63 && cyc <= 66), 1);
    check_val("to_flag", to_a, 1);
    check_val("to_error", err_a, 1);
    check_val("to_done", done_a, 1);
    check_val("to_errcnt", errcnt_a, 0);
    check_val("to_valids_low", {awvalid_a, wvalid_a, arvalid_a, bready_a, rready_a}, 0);
    ar_block = 1'b0;
    tick(2);

    // Reset while in WR_RESP, then a clean pass
    b_hold = 1'b1;
    pulse_a();
    wait_a(2, 50, cyc);
    check_val("wr_resp_reached", bready_a, 1);
    rst_a = 1'b1;
    tick(1);
    check_val("mid_rst_outs", {awvalid_a, wvalid_a, bready_a, arvalid_a, rready_a,
                               done_a, err_a, to_a, errcnt_a}, 64'h0);
    rst_a = 1'b0; b_hold = 1'b0;
    tick(2);
    w0 = wcnt_a;
    pulse_a();
    wait_a(0, 200, cyc);
    check_val("post_rst_done", done_a, 1);
    check_val("post_rst_errcnt", errcnt_a, 0);
    check_val("post_rst_error", err_a, 0);
    check_pass_a("post_rst", w0);
    check_val("a_valid_drops", viol_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
